wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 96 +++++++++
 tb/tb_wb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB stage register feeding a 32x32 register file with two bypassed read ports
// Entry 0 is hardwired to zero; reads forward in-flight MEM and WB results, MEM first.
module wb_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic        re1,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic        re2,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata
);

   logic [4:0]  wd_q,    wd_d;
   logic        wreg_q,  wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] regs_q [32];

   // Flush wins over stall so a squashed instruction never retires.
   always_comb begin
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if (flush) begin
         wd_d    = 5'd0;
         wreg_d  = 1'b0;
         wdata_d = 32'h0;
      end else if (!stall) begin
         wd_d    = mem_wd;
         wreg_d  = mem_wreg;
         wdata_d = mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q    <= 5'd0;
         wreg_q  <= 1'b0;
         wdata_q <= 32'h0;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else begin
         wd_q    <= wd_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         if (wreg_q && (wd_q != 5'd0)) begin
            regs_q[wd_q] <= wdata_q;
         end
      end
   end

   function automatic logic [31:0] read_port(
      input logic        rst_n_v,
      input logic        re_v,
      input logic [4:0]  addr_v,
      input logic [4:0]  m_wd_v,
      input logic        m_wreg_v,
      input logic [31:0] m_wdata_v,
      input logic [4:0]  w_wd_v,
      input logic        w_wreg_v,
      input logic [31:0] w_wdata_v,
      input logic [31:0] arr_v
   );
      logic [31:0] res;
      res = arr_v;
      if (!rst_n_v || !re_v || (addr_v == 5'd0)) begin
         res = 32'h0;
      end else if (m_wreg_v && (m_wd_v == addr_v)) begin
         res = m_wdata_v;
      end else if (w_wreg_v && (w_wd_v == addr_v)) begin
         res = w_wdata_v;
      end
      return res;
   endfunction

   always_comb begin
      rdata1 = read_port(rst, re1, raddr1, mem_wd, mem_wreg, mem_wdata,
                         wd_q, wreg_q, wdata_q, regs_q[raddr1]);
      rdata2 = read_port(rst, re2, raddr2, mem_wd, mem_wreg, mem_wdata,
                         wd_q, wreg_q, wdata_q, regs_q[raddr2]);
   end

   assign wb_wd    = wd_q;
   assign wb_wreg  = wreg_q;
   assign wb_wdata = wdata_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against an array-based reference model
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic [4:0]  mem_wd = '0;
   logic        mem_wreg = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic        re1 = 1'b0, re2 = 1'b0;
   logic [4:0]  raddr1 = '0, raddr2 = '0;
   logic [31:0] rdata1, rdata2;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;

   wb_regfile dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   // Reference model: architectural register contents plus the one in-flight WB result.
   logic [31:0] m_arr [32];
   logic [4:0]  m_wd;
   logic        m_wreg;
   logic [31:0] m_wdata;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_arr[i] = 32'h0;
      m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'h0;
   endtask

   task automatic model_clock();
      if (rst) begin
         if (m_wreg && m_wd != 5'd0) m_arr[m_wd] = m_wdata;
         if (flush) begin
            m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'h0;
         end else if (!stall) begin
            m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata;
         end
      end
   endtask

   function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
      if (!rst || !re || a == 5'd0) return 32'h0;
      if (mem_wreg && mem_wd == a) return mem_wdata;
      if (m_wreg && m_wd == a) return m_wdata;
      return m_arr[a];
   endfunction

   task automatic cyc(input logic rst_v, input logic st, input logic fl,
                      input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                      input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2);
      exp_t e;
      @(posedge clk);
      model_clock();
      #2;
      rst = rst_v; stall = st; flush = fl;
      mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
      re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
      if (!rst_v) model_reset();
      #1;
      e.r1 = m_read(re1, raddr1);
      e.r2 = m_read(re2, raddr2);
      e.wd = m_wd; e.wreg = m_wreg; e.wdata = m_wdata;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata1",   rdata1, e.r1);
            chk("rdata2",   rdata2, e.r2);
            chk("wb_wd",    {27'd0, wb_wd}, {27'd0, e.wd});
            chk("wb_wreg",  {31'd0, wb_wreg}, {31'd0, e.wreg});
            chk("wb_wdata", wb_wdata, e.wdata);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      model_reset();
      // Reset state
      cyc(0, 0, 0, 5'd3, 1, 32'h1234, 1, 5'd3, 1, 5'd1);
      cyc(0, 0, 0, 5'd3, 1, 32'h1234, 1, 5'd3, 1, 5'd1);
      // Write then read through MEM, WB and array
      cyc(1, 0, 0, 5'd5, 1, 32'hDEADBEEF, 1, 5'd5, 0, 5'd0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd5, 1, 5'd5);
      // Bypass priority
      cyc(1, 0, 0, 5'd7, 1, 32'h1, 0, 5'd0, 0, 5'd0);
      cyc(1, 0, 0, 5'd7, 1, 32'h2, 0, 5'd0, 0, 5'd0);
      cyc(1, 0, 0, 5'd7, 1, 32'h3, 1, 5'd7, 1, 5'd7);
      cyc(1, 1, 0, 5'd7, 1, 32'h3, 1, 5'd7, 1, 5'd7);
      cyc(1, 1, 0, 5'd7, 0, 32'h3, 1, 5'd7, 1, 5'd7);
      // Zero register
      cyc(1, 0, 0, 5'd0, 1, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd0, 1, 5'd0);
      // Stall holds, flush beats stall
      cyc(1, 0, 0, 5'd9, 1, 32'hA5, 1, 5'd9, 0, 5'd0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 5'(10 + i), 1, 32'hC0 + i, 1, 5'd9, 0, 5'd0);
      cyc(1, 1, 1, 5'd12, 1, 32'hBB, 1, 5'd9, 0, 5'd0);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd9, 0, 5'd0);
      // Async reset between edges
      cyc(1, 0, 0, 5'd3, 1, 32'h55, 1, 5'd3, 0, 5'd0);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd3, 0, 5'd0);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd3, 0, 5'd0);
      cyc(0, 0, 0, 5'd3, 1, 32'h66, 1, 5'd3, 0, 5'd0);
      cyc(0, 0, 0, 5'd3, 1, 32'h66, 1, 5'd3, 0, 5'd0);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd3, 0, 5'd0);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 1, 5'd3, 0, 5'd0);
      // Read enable
      cyc(1, 0, 0, 5'd4, 1, 32'h77, 0, 5'd0, 0, 5'd0);
      for (int i = 0; i < 2; i++) cyc(1, 0, 0, 5'd0, 0, 32'h0, 0, 5'd0, 0, 5'd4);
      cyc(1, 0, 0, 5'd0, 0, 32'h0, 0, 5'd0, 1, 5'd4);
      // Random traffic on a narrow address range to exercise bypass collisions
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 59) != 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
             ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
      end
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
